// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of one shared radix-4 Booth 32x32 signed multiplier.
// Two-stage pipeline (operands, product) with a valid/ready response port tagged by requester id.
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_result,
  output logic                 busy
);

  localparam int IW1 = ID_W + 1;
  localparam logic [ID_W:0] NREQ = IW1'(NUM_REQ);

  logic            s1_valid_reg, s2_valid_reg;
  logic [ID_W-1:0] s1_id_reg, s2_id_reg, rr_ptr_reg;
  logic [31:0]     s1_a_reg, s1_b_reg;
  logic [63:0]     s2_result_reg;

  logic s2_load, s1_free, accept;
  logic [ID_W-1:0] gnt;
  logic            gnt_found;
  logic [ID_W:0]   idx, gnt_inc;
  logic [ID_W-1:0] rr_ptr_next;
  logic [31:0]     a_sel, b_sel;
  logic [63:0]     product;

  assign s2_load = s1_valid_reg && (!s2_valid_reg || rsp_ready);
  assign s1_free = !s1_valid_reg || s2_load;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_reg} + IW1'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
        gnt       = idx[ID_W-1:0];
        gnt_found = 1'b1;
      end
    end
  end

  assign accept = gnt_found && s1_free;

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    gnt_inc     = {1'b0, gnt} + IW1'(1);
    rr_ptr_next = (gnt_inc == NREQ) ? '0 : gnt_inc[ID_W-1:0];
  end

  assign a_sel = req_a[32*gnt +: 32];
  assign b_sel = req_b[32*gnt +: 32];

  // Radix-4 Booth: digit j recodes {b[2j+1], b[2j], b[2j-1]} into -2..+2 times a.
  logic [63:0] a_ext;
  logic [32:0] b_pad;
  logic [63:0] pp [16];

  assign a_ext = {{32{s1_a_reg[31]}}, s1_a_reg};
  assign b_pad = {s1_b_reg, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pp
      logic [2:0]  trip;
      logic [63:0] mag;
      assign trip = b_pad[2*gi+2 -: 3];
      always_comb begin
        case (trip)
          3'b001, 3'b010: mag = a_ext;
          3'b011:         mag = a_ext << 1;
          3'b100:         mag = -(a_ext << 1);
          3'b101, 3'b110: mag = -a_ext;
          default:        mag = '0;
        endcase
      end
      assign pp[gi] = mag << (2*gi);
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int j = 0; j < 16; j++) product = product + pp[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_id_reg     <= '0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_id_reg     <= '0;
      s2_result_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_id_reg    <= gnt;
        s1_a_reg     <= a_sel;
        s1_b_reg     <= b_sel;
        rr_ptr_reg   <= rr_ptr_next;
      end else if (s1_free) begin
        s1_valid_reg <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_reg  <= 1'b1;
        s2_id_reg     <= s1_id_reg;
        s2_result_reg <= product;
      end else if (s2_valid_reg && rsp_ready) begin
        s2_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid  = s2_valid_reg;
  assign rsp_id     = s2_id_reg;
  assign rsp_result = s2_result_reg;
  assign busy       = s1_valid_reg || s2_valid_reg;

endmodule
